// File: rtl/audio_level_meter.sv
// audio_level_meter
//   AXI-Stream sink for the i2s2 receive path. Absorbs one stereo frame
//   (left word with last=0, then right word with last=1). The louder channel's
//   magnitude feeds a peak-hold / decaying-peak envelope. A log-scaled LED bar
//   is driven from that envelope.
//
//   Handshake: a word transfers on any rising clk_i edge where valid_i and
//   ready_o are both high. ready_o is registered. It is low during reset and
//   for the single UPDATE cycle that follows each right-channel word.
//
//   Ports
//     clk_i        system / axis clock
//     reset_i      synchronous, active-high reset
//     data_i       rx sample, two's complement, width_p bits
//     valid_i      rx word valid
//     last_i       1 = right-channel word (closes the frame)
//     ready_o      sink ready
//     peak_o       current envelope, unsigned, width_p-1 bits
//     frame_o      one-cycle pulse when a frame has been absorbed
//     led_o        bar display, bit leds_p-1 = loudest
//     clip_o       clip indicator (0 unless clip detection is built in)
//     dbg_state_o  FSM state (0 = WAIT_L, 1 = WAIT_R, 2 = UPDATE)
//
//   Build option
//     AUDIO_LEVEL_METER_CLIP_DETECT_EN : when defined, clip_o flags frames
//     containing a full-scale sample. It then stays high for hold_frames_p
//     further frames. When undefined, clip_o is tied low.
module audio_level_meter #(
    parameter int width_p       = 24,
    parameter int leds_p        = 5,
    parameter int step_p        = 3,
    parameter int hold_frames_p = 4800,
    parameter int decay_shift_p = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [width_p-1:0]   data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [width_p-2:0]   peak_o,
    output logic                 frame_o,
    output logic [leds_p-1:0]    led_o,
    output logic                 clip_o,
    output logic [1:0]           dbg_state_o
);

    localparam int PW = width_p - 1;
    localparam int HW = (hold_frames_p > 0) ? $clog2(hold_frames_p + 1) : 1;

    typedef enum logic [1:0] {
        WAIT_L = 2'd0,
        WAIT_R = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic              accept;
    logic              cap_l, cap_r;
    logic [PW-1:0]     mag_l_q, mag_r_q;
    logic [PW-1:0]     mag;
    logic [PW-1:0]     peak_q, peak_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              frame_q;
    logic [leds_p-1:0] led_q, led_d;

    // Magnitude in PW bits. The most-negative code has no positive
    // counterpart, so it saturates to full scale.
    function automatic logic [PW-1:0] mag_f(input logic [width_p-1:0] x);
        logic [width_p-1:0] neg;
        logic [PW-1:0]      r;
        neg = -x;
        if (!x[width_p-1]) begin
            r = x[PW-1:0];
        end else if (x[PW-1:0] == '0) begin
            r = '1;
        end else begin
            r = neg[PW-1:0];
        end
        return r;
    endfunction

    assign accept = valid_i & ready_q;
    // Any accepted left word (re)loads L. This also covers a repeated
    // last=0 word while waiting for the right channel.
    assign cap_l  = accept & ~last_i;
    assign cap_r  = accept & last_i & (state_q == WAIT_R);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= WAIT_L;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_L: begin
                // A stray right word is dropped here, which resyncs the channels.
                if (accept && !last_i) state_d = WAIT_R;
            end
            WAIT_R: begin
                if (accept && last_i) state_d = UPDATE;
            end
            UPDATE:  state_d = WAIT_L;
            default: state_d = WAIT_L;
        endcase
    end

    // ---------------- Sample capture ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mag_l_q <= '0;
            mag_r_q <= '0;
        end else begin
            if (cap_l) mag_l_q <= mag_f(data_i);
            if (cap_r) mag_r_q <= mag_f(data_i);
        end
    end

    assign mag = (mag_l_q >= mag_r_q) ? mag_l_q : mag_r_q;

    // ---------------- Envelope ----------------
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (state_q == UPDATE) begin
            if (mag >= peak_q) begin
                peak_d = mag;
                hold_d = HW'(hold_frames_p);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HW'(1);
            end else begin
                // The subtrahend reaches zero for small peaks, so the
                // envelope settles there instead of wrapping.
                peak_d = peak_q - (peak_q >> decay_shift_p);
            end
        end
    end

    // LED i lights when the envelope reaches 2^(PW-1 - step_p*(leds_p-1-i)).
    for (genvar i = 0; i < leds_p; i++) begin : g_led
        localparam int E = width_p - 2 - step_p * (leds_p - 1 - i);
        if (E >= 0) begin : g_thr
            assign led_d[i] = (peak_d >= (PW'(1) << E));
        end else begin : g_any
            assign led_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ready_q <= 1'b0;
            peak_q  <= '0;
            hold_q  <= '0;
            frame_q <= 1'b0;
            led_q   <= '0;
        end else begin
            ready_q <= (state_d != UPDATE);
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            frame_q <= (state_q == UPDATE);
            led_q   <= led_d;
        end
    end

    // ---------------- Clip detection ----------------
`ifdef AUDIO_LEVEL_METER_CLIP_DETECT_EN
    logic          clip_l_q, clip_r_q;
    logic          clip_q, clip_d;
    logic [HW-1:0] clip_cnt_q, clip_cnt_d;
    logic          raw_full;

    assign raw_full = (data_i == {1'b0, {PW{1'b1}}}) ||
                      (data_i == {1'b1, {PW{1'b0}}});

    always_comb begin
        clip_d     = clip_q;
        clip_cnt_d = clip_cnt_q;
        if (state_q == UPDATE) begin
            if (clip_l_q || clip_r_q) begin
                clip_d     = 1'b1;
                clip_cnt_d = HW'(hold_frames_p);
            end else if (clip_cnt_q != '0) begin
                clip_cnt_d = clip_cnt_q - HW'(1);
            end else begin
                clip_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clip_l_q   <= 1'b0;
            clip_r_q   <= 1'b0;
            clip_q     <= 1'b0;
            clip_cnt_q <= '0;
        end else begin
            if (cap_l) clip_l_q <= raw_full;
            if (cap_r) clip_r_q <= raw_full;
            clip_q     <= clip_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_o = clip_q;
`else
    assign clip_o = 1'b0;
`endif

    assign ready_o     = ready_q;
    assign peak_o      = peak_q;
    assign frame_o     = frame_q;
    assign led_o       = led_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;

    localparam int W     = 24;
    localparam int LEDS  = 5;
    localparam int HOLD  = 4800;
    localparam int DSH   = 10;
    localparam int EW    = 1 + LEDS + (W - 1);

    // ---------------- Clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data = '0;
    logic          valid = 1'b0;
    logic          last = 1'b0;
    logic          ready_o;
    logic [W-2:0]  peak_o;
    logic          frame_o;
    logic [LEDS-1:0] led_o;
    logic          clip_o;
    logic [1:0]    dbg_state_o;

    always #5 clk = ~clk;

    audio_level_meter dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .data_i      (data),
        .valid_i     (valid),
        .last_i      (last),
        .ready_o     (ready_o),
        .peak_o      (peak_o),
        .frame_o     (frame_o),
        .led_o       (led_o),
        .clip_o      (clip_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- Checking ----------------
    int n_cmp = 0;
    int n_err = 0;
    int frames_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    logic [EW-1:0] exp_q[$];
    int unsigned m_peak, m_hold, m_clip_cnt;
    bit          m_clip;
    bit          m_have_l;
    logic [W-1:0] m_l;

    function automatic int unsigned mag_of(input logic [W-1:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32'h7FFFFF) v = 32'h7FFFFF;
        return v;
    endfunction

    function automatic bit is_full(input logic [W-1:0] x);
        return (x == 24'h7FFFFF) || (x == 24'h800000);
    endfunction

    task automatic model_reset();
        m_peak = 0; m_hold = 0; m_clip = 0; m_clip_cnt = 0;
        m_have_l = 0; m_l = '0;
        exp_q.delete();
    endtask

    task automatic model_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        int unsigned mag;
        logic [LEDS-1:0] led;
        bit clip_now;
        mag = (mag_of(l) > mag_of(r)) ? mag_of(l) : mag_of(r);
        if (mag >= m_peak) begin
            m_peak = mag;
            m_hold = HOLD;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            m_peak = m_peak - (m_peak >> DSH);
        end
        led = '0;
        for (int i = 0; i < LEDS; i++)
            if (m_peak >= (32'd1 << (22 - 3 * (4 - i)))) led[i] = 1'b1;
        clip_now = 1'b0;
`ifdef AUDIO_LEVEL_METER_CLIP_DETECT_EN
        if (is_full(l) || is_full(r)) begin
            m_clip = 1; m_clip_cnt = HOLD;
        end else if (m_clip_cnt > 0) begin
            m_clip_cnt--;
        end else begin
            m_clip = 0;
        end
        clip_now = m_clip;
`endif
        exp_q.push_back({clip_now, led, m_peak[W-2:0]});
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic l);
        if (!l) begin
            m_have_l = 1; m_l = d;
        end else if (m_have_l) begin
            m_have_l = 0;
            model_frame(m_l, d);
        end
    endtask

    // Frame monitor: every frame_o pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (!reset && frame_o) begin
            frames_seen++;
            if (exp_q.size() == 0) begin
                chk("frame_unexpected", 64'd1, 64'd0);
            end else begin
                chk("frame_result", {clip_o, led_o, peak_o}, exp_q.pop_front());
            end
        end
    end

    // ---------------- Driver tasks (entered at a negedge) ----------------
    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int waited;
        waited = 0;
        valid = 1'b1; data = d; last = l;
        while (!ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) begin
            chk("ready_timeout", 64'd0, 64'd1);
            valid = 1'b0;
            return;
        end
        model_accept(d, l);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        send_word(l, 1'b0);
        send_word(r, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_peak", peak_o, 0);
        chk("rst_led", led_o, 0);
        chk("rst_ready", ready_o, 0);
        chk("rst_frame", frame_o, 0);
        chk("rst_clip", clip_o, 0);
        chk("rst_state", dbg_state_o, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_sample();
        logic [31:0] r;
        logic [W-1:0] d;
        r = $urandom;
        if ($urandom_range(0, 19) == 0) return ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
        d = r[W-1:0] >> $urandom_range(0, 23);
        if ($urandom_range(0, 1) != 0) d = -d;
        return d;
    endfunction

    // ---------------- Stimulus ----------------
    initial begin
        int f0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Basic frame: small L, negative R.
        send_word(24'h000400, 1'b0);
        send_word(24'hFFF000, 1'b1);
        chk("ready_low_after_r", ready_o, 0);
        @(negedge clk);
        chk("t1_frame", frame_o, 1);
        chk("t1_peak", peak_o, 23'h001000);
        chk("t1_led", led_o, 5'b00001);
        chk("t1_ready_back", ready_o, 1);

        // Hold then decay.
        send_pair(24'h400000, 24'h000000);
        idle(2);
        chk("t2_peak", peak_o, 23'h400000);
        chk("t2_led", led_o, 5'b11111);
        for (int i = 0; i < HOLD; i++) send_pair(24'h0, 24'h0);
        idle(2);
        chk("t2_held", peak_o, 23'h400000);
        send_pair(24'h0, 24'h0);
        idle(2);
        chk("t2_decay", peak_o, 23'h3FF000);

        // Stray right word in WAIT_L.
        f0 = frames_seen;
        send_word(24'h000123, 1'b1);
        idle(3);
        chk("t3_no_frame", frames_seen, f0);
        chk("t3_state", dbg_state_o, 0);
        send_pair(24'h000010, 24'h000020);
        idle(2);
        chk("t3_frame_after", frames_seen, f0 + 1);

        // Repeated left word overwrites L.
        do_reset();
        send_word(24'h000010, 1'b0);
        send_word(24'h200000, 1'b0);
        chk("t4_state", dbg_state_o, 1);
        send_word(24'h000000, 1'b1);
        idle(2);
        chk("t4_peak", peak_o, 23'h200000);
        chk("t4_led", led_o, 5'b01111);

        // Most-negative input saturates; clip window.
        send_pair(24'h800000, 24'h000000);
        idle(2);
        chk("t5_peak", peak_o, 23'h7FFFFF);
`ifdef AUDIO_LEVEL_METER_CLIP_DETECT_EN
        chk("t5_clip_on", clip_o, 1);
`else
        chk("t5_clip_on", clip_o, 0);
`endif
        for (int i = 0; i < HOLD; i++) send_pair(24'h0, 24'h0);
        idle(2);
`ifdef AUDIO_LEVEL_METER_CLIP_DETECT_EN
        chk("t5_clip_held", clip_o, 1);
`else
        chk("t5_clip_held", clip_o, 0);
`endif
        send_pair(24'h0, 24'h0);
        idle(2);
        chk("t5_clip_off", clip_o, 0);

        // Reset while waiting for the right channel.
        send_word(24'h300000, 1'b0);
        chk("t6_state", dbg_state_o, 1);
        do_reset();
        f0 = frames_seen;
        send_word(24'h007FFF, 1'b1);
        idle(3);
        chk("t6_stray_no_frame", frames_seen, f0);
        chk("t6_peak", peak_o, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) send_word(rand_sample(), 1'b1);
            else if (kind == 1) send_word(rand_sample(), 1'b0);
            send_pair(rand_sample(), rand_sample());
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
        end
        idle(4);
        chk("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
- AXI-Stream sink on the i2s2 receive path. Consumes stereo sample pairs from rx_axis_p_* (left word, then right word with last=1) and computes a per-frame magnitude.
- Keeps a peak-hold / decaying-peak envelope of that magnitude.
- Drives a log-scaled bar on the board LEDs.
- Pairs with the sine transmit path: the sine block produces the tx stream, this block consumes the rx stream.

Parameters:
- width_p, 24, sample width (two's complement)
- leds_p, 5, number of bar LEDs
- step_p, 3, bits (about 18 dB) between adjacent LED thresholds
- hold_frames_p, 4800, frames the peak is held before decay starts (0.1 s at 48 kHz)
- decay_shift_p, 10, per-frame decay: peak -= peak >> decay_shift_p

Ports:
- clk_i  in  1  system clock (axis clock)
- reset_i  in  1  synchronous, active-high reset
- data_i  in  width_p  rx sample (rx_axis_p_data)
- valid_i  in  1  rx_axis_p_valid
- last_i  in  1  rx_axis_p_last; 1 = right channel word
- ready_o  out  1  rx_axis_p_ready
- peak_o  out  width_p-1  current envelope (unsigned magnitude)
- frame_o  out  1  one-cycle pulse when a frame has been absorbed
- led_o  out  leds_p  bar display, bit leds_p-1 = loudest
- clip_o  out  1  clip indicator (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): state=WAIT_L, ready_o=0, peak_o=0, hold counter=0, frame_o=0, led_o=0, clip_o=0. Asserting reset mid-frame discards any captured left sample. ready_o rises the first cycle after reset deasserts.
- Transfer rule: a word is accepted on a cycle with valid_i & ready_o.
- FSM, three states:
  - WAIT_L: ready_o=1.
    - Accept with last_i=0: capture |L|, go to WAIT_R.
    - Accept with last_i=1 (stray right word): discard, stay in WAIT_L. This resyncs the channels.
  - WAIT_R: ready_o=1.
    - Accept with last_i=1: capture |R|, go to UPDATE.
    - Accept with last_i=0: overwrite L with the new sample, stay in WAIT_R.
  - UPDATE: ready_o=0 for exactly one cycle, then go to WAIT_L.
- Throughput: at most one frame per 3 cycles. This is far above the audio rate; the i2s2 buffers upstream.
- Magnitude:
  - |x| is computed in width_p-1 bits.
  - Most-negative input (-2^(width_p-1)) saturates to 2^(width_p-1)-1.
  - mag = max(|L|, |R|).
- Envelope update (in UPDATE, registered, visible the next cycle):
  - mag >= peak: peak <= mag; hold <= hold_frames_p.
  - Else if hold != 0: hold <= hold-1; peak unchanged.
  - Else: peak <= peak - (peak >> decay_shift_p). Once peak >> decay_shift_p is 0, peak stays constant (no underflow).
- frame_o pulses high the cycle after UPDATE, coincident with the new peak_o.
- LED bar:
  - led_o[i] = (peak >= 2^(width_p-2 - step_p*(leds_p-1-i))), for i = 0..leds_p-1.
  - Registered; updates the same cycle as peak_o.
  - The bar is monotonic, e.g. 5'b00111.
  - Default thresholds: i=4: 2^22, i=3: 2^19, i=2: 2^16, i=1: 2^13, i=0: 2^10.
- valid_i low: the FSM holds its state; no timeout.

Optional Feature:
- Macro: AUDIO_LEVEL_METER_CLIP_DETECT_EN.
- Defined:
  - A frame is clipped if either raw sample equals 2^(width_p-1)-1 or -2^(width_p-1).
  - clip_o goes 1 the cycle after UPDATE of a clipped frame.
  - clip_o stays 1 for hold_frames_p subsequent frames. A new clipped frame reloads the count.
  - Reset clears clip_o and its counter.
- Undefined: clip_o is tied to 0 and no clip logic is instantiated.

Test Plan:
- Reset, then send L=0x000400, last=0 and R=0xFFF000 (-4096), last=1 -> ready_o low for one cycle after R; peak_o=0x001000; frame_o pulses; led_o=5'b00001.
- Send L=0x400000, R=0 -> peak_o=0x400000, led_o=5'b11111. Then send 4800 frames of zeros -> peak unchanged. Frame 4801 -> peak_o=0x400000-0x1000=0x3FF000.
- Send a stray right word (last=1) in WAIT_L -> no frame_o, state stays WAIT_L. A following L/R pair is processed normally.
- Send two consecutive last=0 words (0x000010, then 0x200000), then R=0 -> mag uses 0x200000; led_o=5'b01111.
- Send L=0x800000 -> peak_o=0x7FFFFF. With the macro defined, clip_o=1 for 4800 frames then 0; without it, clip_o stays 0.
- Assert reset while in WAIT_R -> next cycle peak_o=0, led_o=0, ready_o=0. The next R word after reset is discarded as stray.
